// File: rtl/usb_bus_responder_if.sv
// Host-side CW305 parallel register bus: address, strobes, data in/out and pad output enable.
// The host drives address/control/din; the responder drives dout and the tristate enable.
interface usb_bus_responder_if #(
    parameter int pADDR_WIDTH = 21
);
    logic [pADDR_WIDTH-1:0] usb_addr;
    logic [7:0]             usb_din;
    logic                   usb_ncs;
    logic                   usb_nwe;
    logic                   usb_nrd;
    logic [7:0]             usb_dout;
    logic                   usb_isout;

    modport master (
        output usb_addr, usb_din, usb_ncs, usb_nwe, usb_nrd,
        input  usb_dout, usb_isout
    );

    modport slave (
        input  usb_addr, usb_din, usb_ncs, usb_nwe, usb_nrd,
        output usb_dout, usb_isout
    );
endinterface

// File: rtl/usb_bus_responder.sv
// Purpose: decode CW305 USB register-bus accesses into register-bank strobes, read data and FIFO pops.
// Latency: strobes, read data and pad enable are registered, valid one clock-to-q after the nCS-low edge.
// Backpressure: none; one access per nCS-low period, further edges in the same period are ignored.
module usb_bus_responder #(
    parameter int         pADDR_WIDTH   = 21,
    parameter int         pBYTECNT_SIZE = 7,
    parameter logic [2:0] pFIFO_BLOCK   = 3'd0,
    parameter logic [4:0] pFIFO_ADDR    = 5'd0
) (
    input  logic                     usb_clk,
    input  logic                     reset,
    usb_bus_responder_if.slave       bus,
    output logic [2:0]               reg_block,
    output logic [4:0]               reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic                     reg_addrvalid,
    output logic [7:0]               reg_datao,
    input  logic [7:0]               reg_datai,
    output logic                     reg_write,
    output logic                     reg_read,
    output logic                     fifo_pop,
    output logic [7:0]               err_count
);
    localparam int P = pBYTECNT_SIZE;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t state_q, state_d;

    wire [pADDR_WIDTH-1:0] addr_live = bus.usb_addr;
    wire                   unused_addr = ^addr_live;

    wire [P-1:0] bytecnt_live = addr_live[P-1:0];
    wire [4:0]   address_live = addr_live[P+4:P];
    wire [2:0]   block_live   = addr_live[P+7:P+5];

    logic do_write, do_read, do_err, do_pop;

    always_ff @(posedge usb_clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Both enables high with nCS low is not an access: stay idle and keep watching.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!bus.usb_ncs && !(bus.usb_nwe && bus.usb_nrd)) state_d = HOLD;
            HOLD:    if (bus.usb_ncs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        do_write = 1'b0;
        do_read  = 1'b0;
        do_err   = 1'b0;
        do_pop   = 1'b0;
        if (state_q == IDLE && !bus.usb_ncs) begin
            do_write = !bus.usb_nwe &&  bus.usb_nrd;
            do_read  =  bus.usb_nwe && !bus.usb_nrd;
            do_err   = !bus.usb_nwe && !bus.usb_nrd;
            do_pop   = do_read && block_live == pFIFO_BLOCK && address_live == pFIFO_ADDR
                       && bytecnt_live == '0;
        end
    end

    assign reg_addrvalid = (state_q == HOLD);

    always_ff @(posedge usb_clk) begin
        if (reset) begin
            reg_write     <= 1'b0;
            reg_read      <= 1'b0;
            fifo_pop      <= 1'b0;
            reg_block     <= '0;
            reg_address   <= '0;
            reg_bytecnt   <= '0;
            reg_datao     <= '0;
            bus.usb_dout  <= '0;
            bus.usb_isout <= 1'b0;
            err_count     <= '0;
        end else begin
            reg_write <= do_write;
            reg_read  <= do_read;
            fifo_pop  <= do_pop;
            if (do_write || do_read) begin
                reg_block   <= block_live;
                reg_address <= address_live;
                reg_bytecnt <= bytecnt_live;
            end
            if (do_write) reg_datao    <= bus.usb_din;
            if (do_read)  bus.usb_dout <= reg_datai;
            // The pad is released as soon as the host lets go of nRD, even mid-access.
            if (bus.usb_nrd)  bus.usb_isout <= 1'b0;
            else if (do_read) bus.usb_isout <= 1'b1;
            if (do_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_usb_bus_responder.sv
// Randomized bench for usb_bus_responder with a transaction-level reference model.
module tb_usb_bus_responder;
    localparam int         AW = 21;
    localparam int         P  = 7;
    localparam logic [2:0] FB = 3'd0;
    localparam logic [4:0] FA = 5'd0;

    localparam int K_WR = 0, K_RD = 1, K_ERR = 2, K_NOP = 3;

    logic         usb_clk = 1'b0;
    logic         reset;
    logic [2:0]   reg_block;
    logic [4:0]   reg_address;
    logic [P-1:0] reg_bytecnt;
    logic         reg_addrvalid;
    logic [7:0]   reg_datao;
    logic [7:0]   reg_datai;
    logic         reg_write, reg_read, fifo_pop;
    logic [7:0]   err_count;

    usb_bus_responder_if #(.pADDR_WIDTH(AW)) bus ();

    usb_bus_responder #(
        .pADDR_WIDTH(AW), .pBYTECNT_SIZE(P), .pFIFO_BLOCK(FB), .pFIFO_ADDR(FA)
    ) dut (
        .usb_clk(usb_clk), .reset(reset), .bus(bus),
        .reg_block(reg_block), .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
        .reg_addrvalid(reg_addrvalid), .reg_datao(reg_datao), .reg_datai(reg_datai),
        .reg_write(reg_write), .reg_read(reg_read), .fifo_pop(fifo_pop),
        .err_count(err_count)
    );

    always #5 usb_clk = ~usb_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: what the register side should be showing between accesses.
    logic [2:0]   m_blk;
    logic [4:0]   m_adr;
    logic [P-1:0] m_bc;
    logic [7:0]   m_datao, m_dout;
    int           m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_blk = '0; m_adr = '0; m_bc = '0; m_datao = '0; m_dout = '0; m_err = 0;
    endtask

    task automatic chk_held(input bit avld, input bit isout);
        chk("addrvalid", reg_addrvalid, avld);
        chk("isout", bus.usb_isout, isout);
        chk("block", reg_block, m_blk);
        chk("address", reg_address, m_adr);
        chk("bytecnt", reg_bytecnt, m_bc);
        chk("datao", reg_datao, m_datao);
        chk("dout", bus.usb_dout, m_dout);
        chk("err_count", err_count, m_err);
    endtask

    task automatic chk_all_zero();
        chk("rst_write", reg_write, 0);
        chk("rst_read", reg_read, 0);
        chk("rst_pop", fifo_pop, 0);
        chk("rst_avld", reg_addrvalid, 0);
        chk("rst_isout", bus.usb_isout, 0);
        chk("rst_dout", bus.usb_dout, 0);
        chk("rst_datao", reg_datao, 0);
        chk("rst_fields", {reg_block, reg_address, reg_bytecnt}, 0);
        chk("rst_err", err_count, 0);
    endtask

    // One host access; called and returns at a falling edge. nCS stays low for 'hold' edges.
    // With drop_nrd, a read lets go of nRD after the first edge while nCS is still low.
    task automatic access(input int kind, input logic [AW-1:0] a, input logic [7:0] d,
                          input logic [7:0] di, input int hold, input bit drop_nrd);
        logic [2:0]   blk;
        logic [4:0]   adr;
        logic [P-1:0] bc;
        bit           pop;
        bus.usb_addr = a;
        bus.usb_din  = d;
        reg_datai    = di;
        @(negedge usb_clk);
        blk = a[P+7:P+5];
        adr = a[P+4:P];
        bc  = a[P-1:0];
        pop = (kind == K_RD) && blk == FB && adr == FA && bc == 0;
        if (kind == K_WR || kind == K_RD) begin
            m_blk = blk; m_adr = adr; m_bc = bc;
        end
        if (kind == K_WR)  m_datao = d;
        if (kind == K_RD)  m_dout = di;
        if (kind == K_ERR && m_err < 255) m_err++;
        bus.usb_ncs = 1'b0;
        bus.usb_nwe = (kind == K_WR || kind == K_ERR) ? 1'b0 : 1'b1;
        bus.usb_nrd = (kind == K_RD || kind == K_ERR) ? 1'b0 : 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge usb_clk);
            chk("reg_write", reg_write, (k == 0) && kind == K_WR);
            chk("reg_read", reg_read, (k == 0) && kind == K_RD);
            chk("fifo_pop", fifo_pop, (k == 0) && pop);
            chk_held(kind != K_NOP, kind == K_RD && (k == 0 || !drop_nrd));
            if (drop_nrd && kind == K_RD) bus.usb_nrd = 1'b1;
        end
        bus.usb_ncs = 1'b1;
        bus.usb_nwe = 1'b1;
        bus.usb_nrd = 1'b1;
        @(negedge usb_clk);
        chk("rel_strobes", {reg_write, reg_read, fifo_pop}, 0);
        chk_held(1'b0, 1'b0);
    endtask

    initial begin
        logic [AW-1:0] a;
        int            kind;
        reset = 1'b1;
        bus.usb_addr = '0; bus.usb_din = '0;
        bus.usb_ncs = 1'b1; bus.usb_nwe = 1'b1; bus.usb_nrd = 1'b1;
        reg_datai = '0;
        model_reset();
        @(negedge usb_clk);
        @(negedge usb_clk);
        chk_all_zero();
        reset = 1'b0;

        // Directed accesses from the plan.
        access(K_WR, 21'h000D01, 8'hA5, 8'h00, 1, 0);
        chk("wr_fields", {reg_block, reg_address, reg_bytecnt}, {3'd0, 5'd26, 7'd1});
        access(K_RD, 21'h003080, 8'h00, 8'h5C, 1, 0);
        chk("rd_fields", {reg_block, reg_address, reg_bytecnt}, {3'd3, 5'd1, 7'd0});
        access(K_WR, 21'h1ABCDE, 8'h3C, 8'h00, 6, 0);
        access(K_RD, {10'd0, FB, FA, 7'd0}, 8'h00, 8'h77, 1, 0);
        access(K_RD, {10'd0, FB, FA, 7'd1}, 8'h00, 8'h88, 3, 0);
        access(K_RD, 21'h0F0F00, 8'h00, 8'h12, 4, 1);
        access(K_NOP, 21'h012345, 8'h99, 8'h66, 3, 0);

        // Random mix of accesses, biased so FIFO-register reads appear often.
        for (int i = 0; i < 150; i++) begin
            a = AW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                a[P+7:P] = {FB, FA};
                a[P-1:0] = P'($urandom_range(0, 1));
            end
            kind = $urandom_range(0, 3);
            access(kind, a, 8'($urandom), 8'($urandom), $urandom_range(1, 6), 1'($urandom_range(0, 1)));
        end

        // Push the error counter past saturation.
        for (int i = 0; i < 300; i++) access(K_ERR, AW'($urandom), 8'h00, 8'h00, 1, 0);
        chk("err_sat", err_count, 255);

        // Reset in the middle of a held read, then restart from the still-low nCS.
        bus.usb_addr = 21'h004A83; reg_datai = 8'hE1;
        @(negedge usb_clk);
        bus.usb_ncs = 1'b0; bus.usb_nrd = 1'b0;
        @(negedge usb_clk);
        chk("pre_rst_read", reg_read, 1);
        reset = 1'b1;
        @(negedge usb_clk);
        chk_all_zero();
        model_reset();
        reset = 1'b0;
        @(negedge usb_clk);
        chk("restart_read", reg_read, 1);
        m_blk = 3'd4; m_adr = 5'd21; m_bc = 7'd3; m_dout = 8'hE1;
        chk_held(1'b1, 1'b1);
        bus.usb_ncs = 1'b1; bus.usb_nrd = 1'b1;
        @(negedge usb_clk);
        chk_held(1'b0, 1'b0);

        // Reset coincident with nCS low: no write strobe, nothing latched.
        reset = 1'b1;
        bus.usb_ncs = 1'b0; bus.usb_nwe = 1'b0; bus.usb_din = 8'hFF;
        @(negedge usb_clk);
        chk_all_zero();
        model_reset();
        reset = 1'b0;
        bus.usb_ncs = 1'b1; bus.usb_nwe = 1'b1;
        @(negedge usb_clk);
        chk("post_rst_write", reg_write, 0);
        chk_held(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/usb_bus_responder.md
# usb_bus_responder

Target-side responder for the CW305 8-bit parallel USB register bus. Samples the host-driven usb_addr, nCS, nWE and nRD signals on usb_clk and decodes each access into block, register and byte-count fields. Issues single-cycle write and read strobes to the register banks and drives read data back onto the bus, with output-enable control for the top-level tristate. Also generates a FIFO pop strobe and counts bus-protocol violations.

## Interface
One clock (usb_clk); reset is synchronous and active-high.

Parameters:
- pADDR_WIDTH, 21, width of usb_addr
- pBYTECNT_SIZE, 7, number of low address bits forming the byte count
- pFIFO_BLOCK, 3'd0, block whose read pops the sniff FIFO
- pFIFO_ADDR, 5'd0, register address whose read pops the sniff FIFO

Ports:
- usb_clk  in  1  bus clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- usb_addr  in  pADDR_WIDTH  host address
- usb_din  in  8  bus data from pad
- usb_ncs  in  1  chip select, active-low
- usb_nwe  in  1  write enable, active-low
- usb_nrd  in  1  read enable, active-low
- usb_dout  out  8  read data to pad
- usb_isout  out  1  pad output enable
- reg_block  out  3  latched block field
- reg_address  out  5  latched register field
- reg_bytecnt  out  pBYTECNT_SIZE  latched byte index
- reg_addrvalid  out  1  high while an access is held (state HOLD)
- reg_datao  out  8  latched write data
- reg_datai  in  8  combinational read data for reg_block/reg_address/reg_bytecnt, computed from the live address
- reg_write  out  1  one-cycle write strobe
- reg_read  out  1  one-cycle read strobe
- fifo_pop  out  1  one-cycle FIFO pop strobe
- err_count  out  8  saturating protocol-error count

## Operation
- Address split, with P = pBYTECNT_SIZE:
  - bytecnt = usb_addr[P-1:0]
  - address = usb_addr[P+4:P]
  - block = usb_addr[P+7:P+5]
  - Upper bits are ignored.
- The address fields are latched at transaction start and held until the next start.
- The FSM has two states, IDLE and HOLD. Bus inputs are sampled directly at each edge, with no input register.
- IDLE, usb_ncs=1: no action.
- IDLE, usb_ncs=0 and nwe=0, nrd=1 (write):
  - latch the address fields and reg_datao <= usb_din
  - reg_write=1 for the next cycle
  - go to HOLD
- IDLE, usb_ncs=0 and nrd=0, nwe=1 (read):
  - latch the address fields and usb_dout <= reg_datai, decoded from the live usb_addr
  - usb_isout <= 1, reg_read=1 for the next cycle
  - fifo_pop=1 as well if block==pFIFO_BLOCK, address==pFIFO_ADDR and bytecnt==0
  - go to HOLD
- IDLE, usb_ncs=0 and nwe=0, nrd=0: no strobes; err_count increments, saturating at 255; go to HOLD.
- IDLE, usb_ncs=0 and nwe=1, nrd=1: treated as idle; stay in IDLE.
- HOLD: no further strobes regardless of duration. Return to IDLE on the first edge where usb_ncs=1.
- usb_isout clears on the first edge where usb_nrd is sampled 1, in any state. usb_dout holds its value.
- reset: state IDLE; every output 0, including usb_dout, the latched fields, err_count and usb_isout.

## Timing
- Strobe latency: reg_write, reg_read and fifo_pop rise one clock-to-q after the edge that samples usb_ncs=0. Each is exactly one cycle wide.
- Read data: valid on usb_dout one clock-to-q after the same edge.
- Host constraint: usb_addr must be stable from the edge before nCS is sampled low.
- Back-to-back: one access per nCS low period. A new access needs at least one edge with usb_ncs=1 in between.
- Reset wins over a simultaneously sampled usb_ncs=0: no strobe is issued and err_count stays 0.
- Reset while in HOLD returns to IDLE. If usb_ncs is still low afterwards, the first edge out of reset starts a new access.
- err_count stays at 255 once reached.

## Test plan
- Write: addr=0x0D01, din=0xA5, nwe=0, nCS low for 1 edge -> one reg_write pulse; block=0, address=26, bytecnt=1, reg_datao=0xA5; err_count=0.
- Read: addr=0x3080, reg_datai=0x5C, nrd=0, nCS low -> usb_dout=0x5C and usb_isout=1 right after the sampling edge; one reg_read pulse; usb_isout=0 after the first edge with nrd=1.
- Held select: nCS held low 6 edges during a write -> exactly one reg_write pulse; reg_addrvalid high until the edge that samples nCS=1.
- FIFO pop: read block=pFIFO_BLOCK, address=pFIFO_ADDR, bytecnt=0 -> one fifo_pop pulse. Same access with bytecnt=1 -> no pop.
- Protocol error: nrd=0 and nwe=0 with nCS low, 300 times -> no strobes; err_count saturates at 255.
- Reset: reset asserted during HOLD of a read -> all outputs 0 and state IDLE next cycle. Reset on the same edge as nCS=0 -> no strobe.
